// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one UART transmitter between NUM_REQ requesters. The requesters are
// served in round-robin order. Each grant takes one 9-bit character and
// captures the line configuration present at that moment. The block then
// runs the transmitter for exactly one frame, guards that frame with a
// watchdog, and holds the line idle for GAP_CYCLES before the next grant.
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active high
//   req            per-requester request level, held until its gnt
//   req_data       requester i character at [9*i+8:9*i]
//   cfg_data_bits  character length 5..9, sampled at grant
//   cfg_parity_en  parity bit appended, sampled at grant
//   cfg_stop_bits  2'b01 one stop bit, 2'b10 two stop bits, sampled at grant
//   tx_done        transmitter pulse: last stop bit sent
//   gnt            one-hot pulse: req_data[i] consumed
//   done           one-hot pulse: frame of requester i completed
//   err            pulse: bad configuration or watchdog abort
//   thr            transmitter holding register {7'b0, char}
//   tx_status      {8'b0, stop[1:0], parity_en, data_bits[3:0], enable}
//   tx_start       pulse when a frame is launched
//   busy           high whenever the scheduler is not idle
//   cur_id         requester that currently owns the transmitter
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int GAP_CYCLES      = 16,
    parameter int WATCHDOG_CYCLES = 2_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [9*NUM_REQ-1:0] req_data,
    input  logic [3:0]           cfg_data_bits,
    input  logic                 cfg_parity_en,
    input  logic [1:0]           cfg_stop_bits,
    input  logic                 tx_done,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic [15:0]          thr,
    output logic [15:0]          tx_status,
    output logic                 tx_start,
    output logic                 busy,
    output logic [2:0]           cur_id
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    localparam logic [31:0] WD_LOAD  = 32'(WATCHDOG_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);

    logic [1:0]         state_q,     state_d;
    logic [2:0]         ptr_q,       ptr_d;
    logic [31:0]        gap_cnt_q,   gap_cnt_d;
    logic [31:0]        wd_cnt_q,    wd_cnt_d;
    logic [8:0]         char_q,      char_d;
    logic [3:0]         bits_q,      bits_d;
    logic               parity_q,    parity_d;
    logic [1:0]         stop_q,      stop_d;
    logic [2:0]         cur_id_q,    cur_id_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [NUM_REQ-1:0] done_q,      done_d;
    logic               err_q,       err_d;
    logic [15:0]        thr_q,       thr_d;
    logic [15:0]        tx_status_q, tx_status_d;
    logic               tx_start_q,  tx_start_d;

    logic               found;
    logic [2:0]         win_idx;
    logic [8:0]         win_char;
    logic               cfg_ok;

    // Round-robin pick: the first pass looks at indices at or above the
    // pointer; if none is requesting, the second pass takes the lowest
    // requesting index, which is the wrap-around case.
    always_comb begin
        found    = 1'b0;
        win_idx  = 3'd0;
        win_char = 9'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (3'(i) >= ptr_q)) begin
                found    = 1'b1;
                win_idx  = 3'(i);
                win_char = req_data[9*i +: 9];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                win_idx  = 3'(i);
                win_char = req_data[9*i +: 9];
            end
        end
    end

    // Only lengths 5..9 and one or two stop bits describe a real frame.
    always_comb begin
        cfg_ok = (cfg_data_bits >= 4'd5) && (cfg_data_bits <= 4'd9) &&
                 ((cfg_stop_bits == 2'b01) || (cfg_stop_bits == 2'b10));
    end

    // Next-state logic. Pulse outputs default low every cycle. The enable
    // bit tx_status[0] is set in LOAD and cleared when leaving WAIT_DONE,
    // so the transmitter runs for exactly one frame.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gap_cnt_d   = gap_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        char_d      = char_q;
        bits_d      = bits_q;
        parity_d    = parity_q;
        stop_d      = stop_q;
        cur_id_d    = cur_id_q;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = 1'b0;
        thr_d       = thr_q;
        tx_status_d = tx_status_q;
        tx_start_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        gnt_d[i] = (win_idx == 3'(i));
                    end
                    char_d   = win_char;
                    bits_d   = cfg_data_bits;
                    parity_d = cfg_parity_en;
                    stop_d   = cfg_stop_bits;
                    cur_id_d = win_idx;
                    ptr_d    = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
                    if (cfg_ok) begin
                        state_d = ST_LOAD;
                    end else begin
                        // The character is consumed and dropped.
                        err_d     = 1'b1;
                        gap_cnt_d = GAP_LOAD;
                        state_d   = ST_GAP;
                    end
                end
            end

            ST_LOAD: begin
                thr_d       = {7'b0, char_q};
                tx_status_d = {8'b0, stop_q, parity_q, bits_q, 1'b1};
                tx_start_d  = 1'b1;
                wd_cnt_d    = WD_LOAD;
                state_d     = ST_WAIT_DONE;
            end

            ST_WAIT_DONE: begin
                // tx_done has priority over a watchdog expiring the same cycle.
                if (tx_done) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        done_d[i] = (cur_id_q == 3'(i));
                    end
                    tx_status_d[0] = 1'b0;
                    gap_cnt_d      = GAP_LOAD;
                    state_d        = ST_GAP;
                end else if (wd_cnt_q == 32'd0) begin
                    err_d          = 1'b1;
                    tx_status_d[0] = 1'b0;
                    gap_cnt_d      = GAP_LOAD;
                    state_d        = ST_GAP;
                end else begin
                    wd_cnt_d = wd_cnt_q - 32'd1;
                end
            end

            default: begin
                tx_status_d[0] = 1'b0;
                if (gap_cnt_q == 32'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 32'd1;
                end
            end
        endcase
    end

    // State and output registers; reset clears every output at once, which
    // also drops the transmitter enable in the middle of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            gap_cnt_q   <= 32'd0;
            wd_cnt_q    <= 32'd0;
            char_q      <= 9'd0;
            bits_q      <= 4'd0;
            parity_q    <= 1'b0;
            stop_q      <= 2'd0;
            cur_id_q    <= 3'd0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            thr_q       <= 16'd0;
            tx_status_q <= 16'd0;
            tx_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gap_cnt_q   <= gap_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            char_q      <= char_d;
            bits_q      <= bits_d;
            parity_q    <= parity_d;
            stop_q      <= stop_d;
            cur_id_q    <= cur_id_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            thr_q       <= thr_d;
            tx_status_q <= tx_status_d;
            tx_start_q  <= tx_start_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign thr       = thr_q;
    assign tx_status = tx_status_q;
    assign tx_start  = tx_start_q;
    assign busy      = (state_q != ST_IDLE);
    assign cur_id    = cur_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler with 4 requesters, a 16-cycle gap
// and a 24-cycle watchdog. Expected grants, characters and status words are
// queued when a request is driven and popped when the grant appears.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NREQ = 4;
    localparam int GAP  = 16;
    localparam int WD   = 24;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [9*NREQ-1:0] req_data;
    logic [3:0]        cfg_data_bits;
    logic              cfg_parity_en;
    logic [1:0]        cfg_stop_bits;
    logic              tx_done;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic [15:0]       thr;
    logic [15:0]       tx_status;
    logic              tx_start;
    logic              busy;
    logic [2:0]        cur_id;

    typedef struct {
        logic [3:0]  gnt;
        int          idx;
        logic        cfgOk;
        logic [15:0] thr;
        logic [15:0] status;
    } exp_t;

    exp_t       sb[$];
    int         modelPtr;
    int         nChecks;
    int         nFails;
    logic [3:0] lastGnt;

    uart_tx_scheduler #(
        .NUM_REQ        (NREQ),
        .GAP_CYCLES     (GAP),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .cfg_data_bits(cfg_data_bits),
        .cfg_parity_en(cfg_parity_en),
        .cfg_stop_bits(cfg_stop_bits),
        .tx_done      (tx_done),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .thr          (thr),
        .tx_status    (tx_status),
        .tx_start     (tx_start),
        .busy         (busy),
        .cur_id       (cur_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic timeoutFail(input string tag);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: bound expired, observed none expected event", tag);
    endtask

    function automatic logic [3:0] rrPick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (r[i]) return 4'b0001 << i;
        end
        return 4'b0000;
    endfunction

    function automatic int oneHotIdx(input logic [3:0] oh);
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) return i;
        end
        return 0;
    endfunction

    // Drive a request pattern and queue the frame the scheduler should grant.
    task automatic applyStimulus(input logic [3:0] r);
        exp_t e;
        e.gnt    = rrPick(r, modelPtr);
        e.idx    = oneHotIdx(e.gnt);
        e.cfgOk  = (cfg_data_bits >= 4'd5) && (cfg_data_bits <= 4'd9) &&
                   ((cfg_stop_bits == 2'b01) || (cfg_stop_bits == 2'b10));
        e.thr    = {7'b0, req_data[9*e.idx +: 9]};
        e.status = {8'b0, cfg_stop_bits, cfg_parity_en, cfg_data_bits, 1'b1};
        modelPtr = (e.idx + 1) % NREQ;
        sb.push_back(e);
        req = r;
    endtask

    task automatic applyReset();
        #2 rst = 1'b1;
        #10 rst = 1'b0;
        modelPtr = 0;
        sb.delete();
        tick();
    endtask

    task automatic waitIdle();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (!busy) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) timeoutFail("wait_idle");
    endtask

    // Wait for a grant, compare it with the queued frame, and for a valid
    // configuration step to the launch cycle and compare the register image.
    task automatic checkGrant(input bit dropReq);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (gnt != 4'b0000) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            timeoutFail("gnt_wait");
            return;
        end
        if (sb.size() == 0) begin
            timeoutFail("scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        lastGnt = e.gnt;
        checkOutput("gnt", 32'(gnt), 32'(e.gnt));
        checkOutput("cur_id", 32'(cur_id), 32'(e.idx));
        checkOutput("err_at_gnt", 32'(err), 32'(!e.cfgOk));
        checkOutput("tx_start_at_gnt", 32'(tx_start), 32'd0);
        if (dropReq) req = req & ~e.gnt;
        if (e.cfgOk) begin
            tick();
            checkOutput("tx_start", 32'(tx_start), 32'd1);
            checkOutput("thr", 32'(thr), 32'(e.thr));
            checkOutput("tx_status", 32'(tx_status), 32'(e.status));
            checkOutput("busy_frame", 32'(busy), 32'd1);
        end else begin
            checkOutput("enable_bad_cfg", 32'(tx_status[0]), 32'd0);
        end
    endtask

    initial begin
        bit sawBad;
        bit sawDone;
        int n;

        nChecks       = 0;
        nFails        = 0;
        modelPtr      = 0;
        lastGnt       = 4'b0000;
        rst           = 1'b0;
        req           = 4'b0000;
        tx_done       = 1'b0;
        cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0;
        cfg_stop_bits = 2'b01;
        req_data      = {9'h1FF, 9'h05A, 9'h13C, 9'h0A5};

        // Reset values
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_outputs", {gnt, done, err, tx_start, busy, cur_id}, 32'd0);
        checkOutput("rst_thr", 32'(thr), 32'd0);
        checkOutput("rst_status", 32'(tx_status), 32'd0);
        #10 rst = 1'b0;
        tick();

        // Single frame, tx_done on cycle 20, then the idle gap
        $display("[TB] single frame");
        applyStimulus(4'b0001);
        checkGrant(1'b1);
        repeat (18) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("done_single", 32'(done), 32'(lastGnt));
        checkOutput("err_single", 32'(err), 32'd0);
        checkOutput("enable_gap", 32'(tx_status[0]), 32'd0);
        tick();
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        repeat (14) tick();
        checkOutput("busy_gap_end", 32'(busy), 32'd1);
        tick();
        checkOutput("busy_after_gap", 32'(busy), 32'd0);

        // All requesters held, instant tx_done: strict rotation
        $display("[TB] round robin");
        applyReset();
        for (int f = 0; f < 5; f++) begin
            applyStimulus(4'b1111);
            checkGrant(1'b0);
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            checkOutput("done_rr", 32'(done), 32'(lastGnt));
        end
        req = 4'b0000;
        waitIdle();

        // Invalid character length: grant, error, no launch
        $display("[TB] bad config");
        cfg_data_bits = 4'd4;
        applyStimulus(4'b0100);
        checkGrant(1'b1);
        tick();
        checkOutput("err_one_cycle", 32'(err), 32'd0);
        sawBad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sawBad = sawBad | tx_start | tx_status[0];
            tick();
        end
        checkOutput("no_launch_bad_cfg", 32'(sawBad), 32'd0);
        cfg_data_bits = 4'd8;
        waitIdle();

        // Watchdog abort
        $display("[TB] watchdog");
        cfg_data_bits = 4'd7;
        cfg_parity_en = 1'b1;
        cfg_stop_bits = 2'b10;
        applyStimulus(4'b1000);
        checkGrant(1'b1);
        n = 0;
        sawDone = 1'b0;
        while (n < 200 && !err) begin
            tick();
            n++;
            sawDone = sawDone | (done != 4'b0000);
        end
        checkOutput("wd_err_delay", 32'(n), 32'(WD));
        checkOutput("wd_enable_drop", 32'(tx_status[0]), 32'd0);
        checkOutput("wd_no_done", 32'(sawDone), 32'd0);
        waitIdle();

        // tx_done on the cycle the watchdog reaches zero
        $display("[TB] done vs watchdog");
        cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0;
        cfg_stop_bits = 2'b01;
        applyStimulus(4'b0010);
        checkGrant(1'b1);
        repeat (WD - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("tie_done", 32'(done), 32'(lastGnt));
        checkOutput("tie_err", 32'(err), 32'd0);
        tick();
        checkOutput("tie_err_after", 32'(err), 32'd0);
        waitIdle();

        // Asynchronous reset in WAIT_DONE
        $display("[TB] reset mid-frame");
        applyStimulus(4'b0010);
        checkGrant(1'b1);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_outputs", {gnt, done, err, tx_start, busy, cur_id}, 32'd0);
        checkOutput("arst_status", 32'(tx_status), 32'd0);
        checkOutput("arst_thr", 32'(thr), 32'd0);
        modelPtr = 0;
        sb.delete();
        #10 rst = 1'b0;
        applyStimulus(4'b1111);
        checkGrant(1'b1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("done_after_rst", 32'(done), 32'(lastGnt));
        req = 4'b0000;
        waitIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
